// File: rtl/ijtag_ovr_fi_tdr_if.sv
// rtl/ijtag_ovr_fi_tdr_if.sv - IJTAG scan-port bundle for the override/fault-injection TDR
interface ijtag_ovr_fi_tdr_if;
  logic ijtag_sel;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_si;
  logic ijtag_so;

  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
    input  ijtag_so
  );

  modport slave (
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si,
    output ijtag_so
  );
endinterface

// File: rtl/ijtag_ovr_fi_tdr.sv
// rtl/ijtag_ovr_fi_tdr.sv - IJTAG TDR with functional override and timed fault injection
module ijtag_ovr_fi_tdr #(
  parameter int N     = 3,
  parameter int OBS_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                nRst,
  ijtag_ovr_fi_tdr_if.slave   bus,
  input  logic [N-1:0]        func_in,
  input  logic [OBS_W-1:0]    obs_in,
  output logic [N-1:0]        data_out,
  output logic                fi_en,
  output logic                fi_busy
);

  localparam int L = N + CNT_W + 3;

  logic [L-1:0]     sr;
  logic [L-1:0]     ur;
  logic [L-1:0]     sr_cap;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;

  // Update-register fields
  logic [N-1:0]     ovr_data;
  logic             mux_sel;
  logic             fi_req;
  logic             fi_mode;
  logic [CNT_W-1:0] fi_count;

  // Fields of the shift register as they would land in UR on an update
  logic             sr_req;
  logic             sr_mode;
  logic [CNT_W-1:0] sr_count;
  logic             upd;

  assign ovr_data = ur[N-1:0];
  assign mux_sel  = ur[N];
  assign fi_req   = ur[N+1];
  assign fi_mode  = ur[N+2];
  assign fi_count = ur[N+3 +: CNT_W];

  assign sr_req   = sr[N+1];
  assign sr_mode  = sr[N+2];
  assign sr_count = sr[N+3 +: CNT_W];

  assign upd      = bus.ijtag_sel && bus.ijtag_ue;

  // Capture image: timer activity in bit 0, observed status above it, rest zero
  always_comb begin
    sr_cap          = '0;
    sr_cap[0]       = fi_busy;
    sr_cap[OBS_W:1] = obs_in;
  end

  // Shift register: capture wins over shift; holds when deselected
  always_ff @(posedge clk) begin
    if (!nRst) begin
      sr <= '0;
    end else if (bus.ijtag_sel) begin
      if (bus.ijtag_ce) begin
        sr <= sr_cap;
      end else if (bus.ijtag_se) begin
        sr <= {bus.ijtag_si, sr[L-1:1]};
      end
    end
  end

  // Update register: copies the pre-edge shift register regardless of ce/se
  always_ff @(posedge clk) begin
    if (!nRst) begin
      ur <= '0;
    end else if (upd) begin
      ur <= sr;
    end
  end

  // Pulse timer: an update reloads or clears it, level mode pins it at zero,
  // otherwise it counts down and stops at zero
  always_comb begin
    timer_nxt = timer;
    if (upd) begin
      if (sr_mode && sr_req && (sr_count != '0)) begin
        timer_nxt = sr_count;
      end else begin
        timer_nxt = '0;
      end
    end else if (!fi_mode) begin
      timer_nxt = '0;
    end else if (timer != '0) begin
      timer_nxt = timer - CNT_W'(1);
    end
  end

  // Timer state register
  always_ff @(posedge clk) begin
    if (!nRst) begin
      timer <= '0;
    end else begin
      timer <= timer_nxt;
    end
  end

  assign fi_busy     = (timer != '0);
  assign fi_en       = fi_mode ? fi_busy : fi_req;
  assign data_out    = mux_sel ? ovr_data : func_in;
  assign bus.ijtag_so = sr[0];

  // fi_count is consumed only through the update path (sr_count)
  logic unused_ok;
  assign unused_ok = ^fi_count;

endmodule

// File: tb/tb_ijtag_ovr_fi_tdr.sv
// tb/tb_ijtag_ovr_fi_tdr.sv - randomized and directed bench for ijtag_ovr_fi_tdr
module tb_ijtag_ovr_fi_tdr;
  localparam int N     = 3;
  localparam int OBS_W = 4;
  localparam int CNT_W = 8;
  localparam int L     = N + CNT_W + 3;

  logic             clk = 1'b0;
  logic             nRst;
  logic [N-1:0]     func_in;
  logic [OBS_W-1:0] obs_in;
  logic [N-1:0]     data_out;
  logic             fi_en;
  logic             fi_busy;

  ijtag_ovr_fi_tdr_if bus ();

  ijtag_ovr_fi_tdr #(.N(N), .OBS_W(OBS_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .bus      (bus),
    .func_in  (func_in),
    .obs_in   (obs_in),
    .data_out (data_out),
    .fi_en    (fi_en),
    .fi_busy  (fi_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: scan chain as a bit queue, UR as plain fields,
  // pulse as an absolute end time on a cycle counter
  bit sr_q[$];
  int m_ovr, m_msel, m_req, m_mode;
  int cyc       = 0;
  int pulse_end = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int q_field(int lo, int w);
    int v = 0;
    for (int i = 0; i < w; i++) v += int'(sr_q[lo + i]) << i;
    return v;
  endfunction

  function automatic logic [L-1:0] mk(int ovr, int ms, int rq, int md, int cnt);
    logic [L-1:0] w = '0;
    w[N-1:0]          = ovr[N-1:0];
    w[N]              = ms[0];
    w[N+1]            = rq[0];
    w[N+2]            = md[0];
    w[N+3 +: CNT_W]   = cnt[CNT_W-1:0];
    return w;
  endfunction

  task automatic model_clear();
    sr_q.delete();
    for (int i = 0; i < L; i++) sr_q.push_back(1'b0);
    m_ovr = 0; m_msel = 0; m_req = 0; m_mode = 0;
    pulse_end = 0;
  endtask

  task automatic model_edge(input bit rst_n, sel, ce, se, ue, si);
    bit busy_old;
    int cnt;
    busy_old = (m_mode != 0) && (cyc < pulse_end);
    cyc++;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (sel && ue) begin
      m_ovr  = q_field(0, N);
      m_msel = q_field(N, 1);
      m_req  = q_field(N+1, 1);
      m_mode = q_field(N+2, 1);
      cnt    = q_field(N+3, CNT_W);
      pulse_end = (m_mode != 0 && m_req != 0 && cnt != 0) ? cyc + cnt : cyc;
    end else if (m_mode == 0) begin
      pulse_end = cyc;
    end
    if (sel) begin
      if (ce) begin
        sr_q.delete();
        for (int i = 0; i < L; i++)
          sr_q.push_back(i == 0 ? busy_old : (i <= OBS_W ? obs_in[i-1] : 1'b0));
      end else if (se) begin
        void'(sr_q.pop_front());
        sr_q.push_back(si);
      end
    end
  endtask

  task automatic step(input bit rst_n, sel, ce, se, ue, si);
    bit pulse_on;
    nRst          = rst_n;
    bus.ijtag_sel = sel;
    bus.ijtag_ce  = ce;
    bus.ijtag_se  = se;
    bus.ijtag_ue  = ue;
    bus.ijtag_si  = si;
    @(posedge clk);
    model_edge(rst_n, sel, ce, se, ue, si);
    #1;
    pulse_on = (m_mode != 0) && (cyc < pulse_end);
    chk("so",       bus.ijtag_so, sr_q[0]);
    chk("data_out", data_out, (m_msel != 0) ? m_ovr : func_in);
    chk("fi_en",    fi_en, (m_mode != 0) ? pulse_on : (m_req != 0));
    chk("fi_busy",  fi_busy, pulse_on);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [L-1:0] w);
    for (int i = 0; i < L; i++) step(1, 1, 0, 1, 0, w[i]);
    step(1, 1, 0, 0, 1, 0);
  endtask

  initial begin
    logic [L-1:0] got_chain;
    int n;
    func_in = 3'b101;
    obs_in  = 4'hA;
    model_clear();

    // 1: reset state and capture of obs_in
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("rst_data_out", data_out, 3'b101);
    chk("rst_fi_en", fi_en, 0);
    chk("rst_so", bus.ijtag_so, 0);
    step(1, 1, 1, 0, 0, 0);
    got_chain = '0;
    for (int i = 0; i < L; i++) begin
      got_chain[i] = bus.ijtag_so;
      step(1, 1, 0, 1, 0, 0);
    end
    chk("cap_chain", got_chain, 14'h0014);

    // 2: override then release
    load(mk(3'b010, 1, 0, 0, 0));
    func_in = 3'b111;
    idle(2);
    chk("ovr_data", data_out, 3'b010);
    load(mk(3'b010, 0, 0, 0, 0));
    func_in = 3'b001;
    idle(1);
    chk("ovr_release", data_out, 3'b001);

    // 3: 5-cycle pulse, then capture of busy mid-pulse
    load(mk(0, 0, 1, 1, 5));
    n = fi_en;
    for (int i = 0; i < 10; i++) begin idle(1); n += fi_en; end
    chk("pulse_len", n, 5);
    load(mk(0, 0, 1, 1, 5));
    idle(1);
    step(1, 1, 1, 0, 0, 0);
    chk("cap_busy", bus.ijtag_so, 1);

    // 4: reload during an active pulse, then cancel one
    load(mk(0, 0, 1, 1, 40));
    load(mk(0, 0, 1, 1, 3));
    n = fi_en;
    for (int i = 0; i < 10; i++) begin idle(1); n += fi_en; end
    chk("reload_len", n, 3);
    load(mk(0, 0, 1, 1, 40));
    load(mk(0, 0, 0, 1, 5));
    chk("cancel", fi_en, 0);

    // 5: level mode holds, zero count never pulses
    load(mk(0, 0, 1, 0, 9));
    idle(40);
    chk("level_hold", fi_en, 1);
    load(mk(0, 0, 1, 1, 0));
    n = fi_en;
    for (int i = 0; i < 10; i++) begin idle(1); n += fi_en; end
    chk("zero_count", n, 0);

    // 6: reset mid-pulse and mid-shift; deselected register holds
    load(mk(0, 0, 1, 1, 200));
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    chk("rst_mid_fi", fi_en, 0);
    chk("rst_mid_so", bus.ijtag_so, 0);
    load(mk(3'b011, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 1, 1);
    chk("desel_hold", data_out, 3'b011);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      func_in = N'($urandom);
      obs_in  = OBS_W'($urandom);
      step(($urandom % 200) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
           ($urandom % 2) == 0, ($urandom % 12) == 0, $urandom % 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
